rf_write_arbiter: RTL and testbench

//  Shares the single register-file write port among N_REQ writeback sources (ALU result, load data, ...).
//  Per-source valid/ready handshake; round-robin grant. Winner is registered and drives WriteEn/Waddr/DataIn
//  of the register file one cycle later. Sits between the execute/memory stages and the register file.

---
 rtl/rf_pkg.sv | 20 ++
 rtl/rf_write_arbiter_rr.sv | 36 +++
 rtl/rf_write_arbiter.sv | 94 +++++++++
 tb/tb_rf_write_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file types and sizing for the write arbiter slice.
// Optional forwarding is enabled by defining RF_WR_BYPASS_EN (see rf_write_arbiter).
package rf_pkg;
   localparam int RF_W        = 8;
   localparam int RF_D        = 4;
   localparam int RF_NREQ_MAX = 4;

   typedef logic [RF_D-1:0] rf_addr_t;
   typedef logic [RF_W-1:0] rf_data_t;

   typedef struct packed {
      rf_addr_t addr;
      rf_data_t data;
   } rf_wr_t;

   // A single requester still needs a one-bit pointer.
   function automatic int rf_ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/rf_write_arbiter_rr.sv
// Combinational round-robin picker.
// Grants the first request at or after ptr, wrapping modulo N.
module rr_arbiter
   import rf_pkg::*;
#(
   parameter int N = 2,
   localparam int PW = rf_ptr_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic          en,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx
);

   int idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      idx     = 0;
      if (en) begin
         // Walk from the farthest offset back to ptr so the closest request wins.
         for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx -= N;
            if (req[idx]) begin
               gnt      = '0;
               gnt[idx] = 1'b1;
               gnt_idx  = PW'(idx);
            end
         end
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among N_REQ sources.
// Define RF_WR_BYPASS_EN to add read-port forwarding of the pending write.
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int W       = RF_W,
   parameter int D       = RF_D,
   parameter int N_REQ   = 2,
   parameter int ZERO_WR = 0
) (
   input  logic               Clk,
   input  logic               Rst_n,
   input  logic               Hold,
   input  logic [N_REQ-1:0]   ReqValid,
   input  logic [N_REQ*D-1:0] ReqAddr,
   input  logic [N_REQ*W-1:0] ReqData,
   output logic [N_REQ-1:0]   ReqReady,
   output logic               WriteEn,
   output logic [D-1:0]       Waddr,
   output logic [W-1:0]       DataIn
`ifdef RF_WR_BYPASS_EN
   ,
   input  logic [D-1:0]       RaddrA,
   input  logic [D-1:0]       RaddrB,
   input  logic [W-1:0]       RfDataA,
   input  logic [W-1:0]       RfDataB,
   output logic [W-1:0]       FwdDataA,
   output logic [W-1:0]       FwdDataB
`endif
);

   localparam int PW = rf_ptr_w(N_REQ);

   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    gnt_idx;
   logic [N_REQ-1:0] gnt;
   logic             transfer;
   logic [D-1:0]     sel_addr;
   logic [W-1:0]     sel_data;
   logic             wen_q, wen_d;
   logic [D-1:0]     waddr_q, waddr_d;
   logic [W-1:0]     wdata_q, wdata_d;

   // Rst_n gates the grant so nothing is acknowledged while reset is asserted.
   rr_arbiter #(.N(N_REQ)) u_rr (
      .req     (ReqValid),
      .en      (Rst_n && !Hold),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign ReqReady = gnt;

   always_comb begin
      transfer = |gnt;
      sel_addr = ReqAddr[int'(gnt_idx)*D +: D];
      sel_data = ReqData[int'(gnt_idx)*W +: W];
      ptr_d    = ptr_q;
      if (transfer) begin
         ptr_d = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
      end
      // A granted write to r0 is consumed but suppressed when r0 is hard-wired.
      wen_d   = transfer && !((ZERO_WR != 0) && (sel_addr == '0));
      waddr_d = transfer ? sel_addr : waddr_q;
      wdata_d = transfer ? sel_data : wdata_q;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ptr_q   <= '0;
         wen_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         wen_q   <= wen_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign WriteEn = wen_q;
   assign Waddr   = waddr_q;
   assign DataIn  = wdata_q;

`ifdef RF_WR_BYPASS_EN
   assign FwdDataA = (wen_q && (waddr_q == RaddrA) && !((ZERO_WR != 0) && (RaddrA == '0)))
                     ? wdata_q : RfDataA;
   assign FwdDataB = (wen_q && (waddr_q == RaddrB) && !((ZERO_WR != 0) && (RaddrB == '0)))
                     ? wdata_q : RfDataB;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized self-checking bench for rf_write_arbiter, with a behavioural reference model.
// Two instances share the stimulus: one default, one with ZERO_WR=1.
module tb_rf_write_arbiter;
   import rf_pkg::*;

   localparam int N = 2;
   localparam int W = RF_W;
   localparam int D = RF_D;

   logic           Clk = 1'b0;
   logic           Rst_n;
   logic           Hold;
   logic [N-1:0]   ReqValid;
   logic [N*D-1:0] ReqAddr;
   logic [N*W-1:0] ReqData;
   logic [N-1:0]   rdy0, rdy1;
   logic           we0, we1;
   logic [D-1:0]   wa0, wa1;
   logic [W-1:0]   wd0, wd1;
`ifdef RF_WR_BYPASS_EN
   logic [D-1:0]   RaddrA = '0, RaddrB = '0;
   logic [W-1:0]   RfDataA = '0, RfDataB = '0;
   logic [W-1:0]   fa0, fb0, fa1, fb1;
`endif

   always #5 Clk = ~Clk;

   rf_write_arbiter #(.W(W), .D(D), .N_REQ(N), .ZERO_WR(0)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Hold(Hold), .ReqValid(ReqValid), .ReqAddr(ReqAddr),
      .ReqData(ReqData), .ReqReady(rdy0), .WriteEn(we0), .Waddr(wa0), .DataIn(wd0)
`ifdef RF_WR_BYPASS_EN
      , .RaddrA(RaddrA), .RaddrB(RaddrB), .RfDataA(RfDataA), .RfDataB(RfDataB),
      .FwdDataA(fa0), .FwdDataB(fb0)
`endif
   );

   rf_write_arbiter #(.W(W), .D(D), .N_REQ(N), .ZERO_WR(1)) dut_z (
      .Clk(Clk), .Rst_n(Rst_n), .Hold(Hold), .ReqValid(ReqValid), .ReqAddr(ReqAddr),
      .ReqData(ReqData), .ReqReady(rdy1), .WriteEn(we1), .Waddr(wa1), .DataIn(wd1)
`ifdef RF_WR_BYPASS_EN
      , .RaddrA(RaddrA), .RaddrB(RaddrB), .RfDataA(RfDataA), .RfDataB(RfDataB),
      .FwdDataA(fa1), .FwdDataB(fb1)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Register files as seen through each DUT's write port.
   rf_data_t rf0 [16] = '{default: '0};
   rf_data_t rf1 [16] = '{default: '0};
   always @(posedge Clk) begin
      if (Rst_n && we0) rf0[wa0] <= wd0;
      if (Rst_n && we1) rf1[wa1] <= wd1;
   end

   // Reference model state.
   int       m_ptr;
   logic     m_we [2];
   rf_addr_t m_wa;
   rf_data_t m_wd;

   function automatic void m_reset();
      m_ptr = 0; m_we[0] = 1'b0; m_we[1] = 1'b0; m_wa = '0; m_wd = '0;
   endfunction

   function automatic int m_grant();
      if (!Rst_n || Hold) return -1;
      for (int k = 0; k < N; k++) begin
         if (ReqValid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic check_outputs(input string ph);
      int g;
      logic [N-1:0] exp_rdy;
      g = m_grant();
      exp_rdy = (g < 0) ? '0 : N'(1 << g);
      chk({ph, ".rdy"}, rdy0, exp_rdy);
      chk({ph, ".rdy_z"}, rdy1, exp_rdy);
      chk({ph, ".we"}, we0, m_we[0]);
      chk({ph, ".we_z"}, we1, m_we[1]);
      chk({ph, ".waddr"}, wa0, m_wa);
      chk({ph, ".wdata"}, wd0, m_wd);
      chk({ph, ".waddr_z"}, wa1, m_wa);
      chk({ph, ".wdata_z"}, wd1, m_wd);
   endtask

   // Called at a negedge with inputs driven; returns at the following negedge.
   task automatic step(input string ph);
      int g;
      rf_addr_t a;
      #1;
      check_outputs(ph);
      g = m_grant();
      @(posedge Clk);
      if (g >= 0) begin
         a       = ReqAddr[g*D +: D];
         m_we[0] = 1'b1;
         m_we[1] = (a != '0);
         m_wa    = a;
         m_wd    = ReqData[g*W +: W];
         m_ptr   = (g + 1) % N;
      end else begin
         m_we[0] = 1'b0;
         m_we[1] = 1'b0;
      end
      @(negedge Clk);
   endtask

   task automatic drive(input logic [N-1:0] v, input logic [D-1:0] a0, input logic [W-1:0] d0,
                        input logic [D-1:0] a1, input logic [W-1:0] d1, input logic h);
      ReqValid = v;
      ReqAddr  = {a1, a0};
      ReqData  = {d1, d0};
      Hold     = h;
   endtask

   task automatic do_reset();
      Rst_n = 1'b0;
      m_reset();
      #1;
      check_outputs("rst");
      @(negedge Clk);
      Rst_n = 1'b1;
   endtask

   int waited [N];
   logic [N-1:0] v;
   logic [N*D-1:0] ra;
   logic [N*W-1:0] rd;

   initial begin
      Rst_n = 1'b0;
      m_reset();
      drive(2'b11, 4'd1, 8'h01, 4'd2, 8'h02, 1'b0);
      repeat (2) @(negedge Clk);

      // 1: reset with both valid, then first grant goes to req0
      #1;
      chk("t1.rdy_in_rst", rdy0, 2'b00);
      chk("t1.we_in_rst", we0, 1'b0);
      check_outputs("t1");
      @(negedge Clk);
      Rst_n = 1'b1;
      #1;
      chk("t1.first_gnt", rdy0, 2'b01);
      step("t1");

      // 2: both valid, grants alternate starting from req0
      do_reset();
      drive(2'b11, 4'd3, 8'h11, 4'd5, 8'h22, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t2.gnt", rdy0, (i % 2) ? 2'b10 : 2'b01);
         step("t2");
         chk("t2.we", we0, 1'b1);
         chk("t2.waddr", wa0, (i % 2) ? 4'd5 : 4'd3);
         chk("t2.wdata", wd0, (i % 2) ? 8'h22 : 8'h11);
      end

      // 3: Hold stalls grants without moving the pointer
      drive(2'b11, 4'd3, 8'h11, 4'd5, 8'h22, 1'b1);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t3.rdy_hold", rdy0, 2'b00);
         step("t3");
         chk("t3.we_hold", we0, 1'b0);
         chk("t3.waddr_held", wa0, 4'd5);
      end
      Hold = 1'b0;
      #1;
      chk("t3.ptr_kept", rdy0, 2'b01);
      step("t3");

      // 4: same destination from both, later grant wins
      do_reset();
      drive(2'b11, 4'd7, 8'hAA, 4'd7, 8'hBB, 1'b0);
      step("t4");
      step("t4");
      drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 1'b0);
      step("t4");
      chk("t4.rf7", rf0[7], 8'hBB);
      chk("t4.rf7_z", rf1[7], 8'hBB);

      // 5: ZERO_WR instance consumes an r0 write without issuing it
      drive(2'b10, 4'd1, 8'h00, 4'd0, 8'h55, 1'b0);
      #1;
      chk("t5.rdy_z", rdy1, 2'b10);
      step("t5");
      chk("t5.we_z", we1, 1'b0);
      chk("t5.we", we0, 1'b1);
      drive(2'b11, 4'd1, 8'h66, 4'd0, 8'h55, 1'b0);
      #1;
      chk("t5.ptr_adv_z", rdy1, 2'b01);
      step("t5");

`ifdef RF_WR_BYPASS_EN
      // 6: forwarding of the pending write onto read port A only
      drive(2'b01, 4'd4, 8'h3C, 4'd0, 8'h00, 1'b0);
      step("t6");
      drive(2'b00, 4'd0, 8'h00, 4'd0, 8'h00, 1'b0);
      RaddrA = 4'd4; RfDataA = 8'h00; RaddrB = 4'd2; RfDataB = 8'h5A;
      #1;
      chk("t6.fwdA", fa0, 8'h3C);
      chk("t6.fwdB", fb0, 8'h5A);
      chk("t6.fwdA_z", fa1, 8'h3C);
      RaddrA = 4'd0;
      @(negedge Clk);
`endif

      // Random phase: sticky requests, random hold, occasional reset
      do_reset();
      v = '0; ra = '0; rd = '0;
      for (int i = 0; i < N; i++) waited[i] = 0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         if ($urandom_range(0, 99) == 0) begin
            Rst_n = 1'b0;
            m_reset();
            #2;
            check_outputs("rnd.rst");
            @(negedge Clk);
            Rst_n = 1'b1;
            v = '0;
            for (int i = 0; i < N; i++) waited[i] = 0;
         end
         for (int i = 0; i < N; i++) begin
            if (!v[i] && ($urandom_range(0, 1) == 1)) begin
               v[i] = 1'b1;
               ra[i*D +: D] = ($urandom_range(0, 4) == 0) ? '0 : D'($urandom);
               rd[i*W +: W] = W'($urandom);
            end else if (v[i] && ($urandom_range(0, 19) == 0)) begin
               v[i] = 1'b0;
               waited[i] = 0;
            end
         end
         ReqValid = v; ReqAddr = ra; ReqData = rd;
         Hold = ($urandom_range(0, 3) == 0);
         #1;
         for (int i = 0; i < N; i++) begin
            if (v[i] && !Hold) begin
               if (rdy0[i]) begin
                  chk("rnd.fair", (waited[i] > N - 1) ? 1 : 0, 0);
                  waited[i] = 0;
                  v[i] = 1'b0;
               end else begin
                  waited[i]++;
               end
            end
         end
         step("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
